scramble_controller: RTL
========================

# scramble_controller

Sequences the 4-bit random move generator into a finite cube scramble. On `start` it draws move codes from the random source. It drops out-of-range codes and any code that would undo the previous move. It hands each accepted move to the cube rotation engine over a valid/ready handshake, with a programmable idle gap between moves. It sits between the random move source and the cube-state/rotation datapath.

## Interface
- `NUM_MOVES`, 20: moves per scramble. Legal range 1..255.
- `GAP_CYCLES`, 4: idle cycles inserted after each accepted move. Legal range 0..255; 0 means no gap.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a scramble. Sampled only in IDLE.
- `abort` in 1: terminate the scramble immediately.
- `rnd` in 4: random move code from the generator; may change every cycle.
- `move_ready` in 1: rotation engine can accept a move.
- `move_valid` out 1: `move_code` is offered to the engine.
- `move_code` out 4: move = face·2 + dir, with face = code[3:1] (0..5) and dir = code[0].
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the last move is accepted.
- `moves_issued` out 8: accepted moves in the current or most recent scramble.

## Operation
- Reset: state IDLE. All outputs are 0: `move_valid`, `move_code`, `busy`, `done`, `moves_issued`. Internal `prev_code` = 0 and `prev_valid` = 0.
- **IDLE**
  - On `start`=1 (and `abort`=0): go to SAMPLE, clear `moves_issued`, clear `prev_valid`.
  - `moves_issued` otherwise holds its last value.
- **SAMPLE**
  - Accept `rnd` when `rnd` < 12 and NOT (`prev_valid` and `rnd` == `prev_code` ^ 1).
  - On accept: register `move_code` <= `rnd`, `move_valid` <= 1, go to ISSUE.
  - On reject: stay in SAMPLE and resample next cycle. There is no rejection limit.
- **ISSUE**
  - Hold `move_valid`=1 and `move_code` stable until `move_valid` and `move_ready` are both high at a rising edge.
  - On handshake: `move_valid` <= 0, `prev_code` <= `move_code`, `prev_valid` <= 1, `moves_issued` += 1.
  - If the new count == `NUM_MOVES`: pulse `done`, go to IDLE.
  - Else if `GAP_CYCLES` = 0: go to SAMPLE.
  - Else: load the gap counter with `GAP_CYCLES` and go to GAP.
- **GAP**
  - Decrement the gap counter each cycle. Go to SAMPLE in the cycle after it reaches 1.
  - This gives exactly `GAP_CYCLES` cycles in GAP.
- **abort**
  - In any non-IDLE state: go to IDLE next edge, with `move_valid` <= 0 and no `done`.
  - `moves_issued` keeps its count.
  - If abort coincides with a handshake, the move counts as delivered: `moves_issued` increments, but `done` is not pulsed even if the count reaches `NUM_MOVES`.
- `start` while `busy` is ignored. `start` and `abort` together in IDLE: abort wins, stay in IDLE.
- Repeating the same move back-to-back is legal. Only the immediate inverse (code ^ 1) is filtered.

## Timing
- `start` sampled at edge k: `busy`=1 after edge k. The first SAMPLE decision is at edge k+1.
- Accept at edge j: `move_valid`/`move_code` visible after edge j, so `rnd`-to-offer latency is 1 cycle.
- Minimum move period, with `move_ready` held high and no rejections: `GAP_CYCLES` + 2 cycles.
- `done` is high for exactly the one cycle following the final handshake edge. `busy` is 0 in that same cycle.
- All outputs are registered. No combinational path from `move_ready` or `rnd` to any output.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ISSUE.
  - `move_valid`, `busy`, `done`, `moves_issued`, `move_code` go to 0 asynchronously.
  - After release, the block stays idle until `start`.
- **Basic run:** `NUM_MOVES`=3, `GAP_CYCLES`=0, `move_ready`=1, `rnd` stream 5,7,2.
  - Codes 5, 7, 2 are issued on consecutive 2-cycle periods.
  - `done` pulses once and `moves_issued`=3.
- **Filtering:** previous move 4; `rnd` held at 5 for 3 cycles, then 13 for 2 cycles, then 9.
  - Neither 5 nor 13 is ever offered; the next `move_code` is 9.
- **Backpressure:** `move_ready`=0 for 10 cycles while `move_valid`=1 with code 6, then `move_ready`=1.
  - Code 6 is held for 10 cycles and accepted exactly once.
  - The gap is then exactly `GAP_CYCLES`=4 cycles.
- **Abort:** `abort` during GAP after 2 moves.
  - IDLE next cycle, `busy`=0, no `done`, `moves_issued`=2.
  - A new `start` resets `moves_issued` to 0 and clears `prev_valid`, so an inverse of the old last move is accepted.
- **Start while busy:** pulse `start` mid-scramble.
  - No effect: count continues and exactly `NUM_MOVES` moves are issued.

Source files
------------

// File: rtl/scramble_controller.sv
// scramble_controller: filters 4-bit random codes into a NUM_MOVES-move cube scramble.
// Latency: rnd accepted at edge j is offered after edge j; minimum move period GAP_CYCLES+2.
// Backpressure: move_code/move_valid held until move_ready; no sampling while a move waits.
module scramble_controller #(
  parameter int NUM_MOVES  = 20,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] rnd,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [3:0] move_code,
  output logic       busy,
  output logic       done,
  output logic [7:0] moves_issued
);

  localparam logic [7:0] NUM_M = 8'(NUM_MOVES);
  localparam logic [7:0] GAP_N = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, SAMPLE, ISSUE, GAP} state_t;

  state_t     state;
  logic [3:0] prev_code;
  logic       prev_valid;
  logic [7:0] gap_cnt;
  logic       rnd_ok;
  logic [7:0] cnt_inc;

  assign cnt_inc = moves_issued + 8'd1;

  // A code is usable if it names one of 6 faces and does not undo the last delivered move
  always_comb begin
    rnd_ok = (rnd < 4'd12) && !(prev_valid && (rnd == (prev_code ^ 4'd1)));
  end

  // Scramble sequencer: state, offered move, move history, gap timer and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      move_valid   <= 1'b0;
      move_code    <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      moves_issued <= 8'd0;
      prev_code    <= 4'd0;
      prev_valid   <= 1'b0;
      gap_cnt      <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state        <= SAMPLE;
            busy         <= 1'b1;
            moves_issued <= 8'd0;
            prev_valid   <= 1'b0;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rnd_ok) begin
            move_code  <= rnd;
            move_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // move_valid is always high here, so move_ready alone completes the handshake
          if (move_ready) begin
            move_valid   <= 1'b0;
            prev_code    <= move_code;
            prev_valid   <= 1'b1;
            moves_issued <= cnt_inc;
            if (abort) begin
              // delivered move still counts, but an aborted scramble never reports done
              state <= IDLE;
              busy  <= 1'b0;
            end else if (cnt_inc == NUM_M) begin
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else if (GAP_N == 8'd0) begin
              state <= SAMPLE;
            end else begin
              gap_cnt <= GAP_N;
              state   <= GAP;
            end
          end else if (abort) begin
            move_valid <= 1'b0;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt <= 8'd1) begin
            state <= SAMPLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
